pixel_scanout: RTL and testbench



---
 rtl/pixel_scanout.sv | 153 +++++++++++++++
 tb/tb_pixel_scanout.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pixel_scanout.sv
// pixel_scanout: 160x120x3 framebuffer written through the plot port and scanned out as 640x480@60 VGA, 4x4 upscaled.
// Optional feature macro PIXEL_SCANOUT_FRAME_PULSE_EN adds a one-clock frame_done pulse at the start of vertical blank.
`timescale 1ns/1ps
module pixel_scanout #(
    parameter int unsigned H_VISIBLE   = 640,
    parameter int unsigned H_FRONT     = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BACK      = 48,
    parameter int unsigned V_VISIBLE   = 480,
    parameter int unsigned V_FRONT     = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BACK      = 33,
    parameter int unsigned SCALE_SHIFT = 2
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [7:0] x,
    input  logic [6:0] y,
    input  logic [2:0] colour,
    input  logic       plot,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_blank_n,
    output logic       vga_r,
    output logic       vga_g,
    output logic       vga_b,
    output logic       vga_pix_en
`ifdef PIXEL_SCANOUT_FRAME_PULSE_EN
    ,
    output logic       frame_done
`endif
);

    localparam int unsigned FB_W     = 160;
    localparam int unsigned FB_H     = 120;
    localparam int unsigned FB_DEPTH = FB_W * FB_H;

    localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic        pix_en;
    logic [9:0]  h;
    logic [9:0]  v;

    logic        hs_raw;
    logic        vs_raw;
    logic        visible;
    logic [14:0] src_x;
    logic [14:0] src_y;
    logic [14:0] rd_addr;

    logic [14:0] addr_q;
    logic        hs_q1;
    logic        vs_q1;
    logic        vis_q1;
    logic        hs_q2;
    logic        vs_q2;
    logic        vis_q2;

    logic        wr_en;
    logic [14:0] wr_addr;
    logic [2:0]  fb [FB_DEPTH];
    logic [2:0]  rd_data;

    // Pixel tick at half the system clock; raster counters step only on ticks.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pix_en <= 1'b0;
            h      <= '0;
            v      <= '0;
        end else begin
            pix_en <= ~pix_en;
            if (pix_en) begin
                if (h == H_LAST) begin
                    h <= '0;
                    v <= (v == V_LAST) ? '0 : v + 1'b1;
                end else begin
                    h <= h + 1'b1;
                end
            end
        end
    end

    always_comb begin
        hs_raw  = !((h >= HS_FIRST) && (h <= HS_LAST));
        vs_raw  = !((v >= VS_FIRST) && (v <= VS_LAST));
        visible = (h < H_VIS) && (v < V_VIS);
        src_x   = 15'(h >> SCALE_SHIFT);
        src_y   = 15'(v >> SCALE_SHIFT);
        // src_y*160 as two shifts; parked at 0 in blanking so the index stays in range.
        rd_addr = visible ? ((src_y << 7) + (src_y << 5) + src_x) : '0;
    end

    // Two-stage output pipeline keeps sync, blank and RAM data aligned.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            addr_q <= '0;
            hs_q1  <= 1'b1;
            vs_q1  <= 1'b1;
            vis_q1 <= 1'b0;
            hs_q2  <= 1'b1;
            vs_q2  <= 1'b1;
            vis_q2 <= 1'b0;
        end else if (pix_en) begin
            addr_q <= rd_addr;
            hs_q1  <= hs_raw;
            vs_q1  <= vs_raw;
            vis_q1 <= visible;
            hs_q2  <= hs_q1;
            vs_q2  <= vs_q1;
            vis_q2 <= vis_q1;
        end
    end

    assign wr_en   = plot && (x < 8'(FB_W)) && (y < 7'(FB_H));
    assign wr_addr = (15'(y) << 7) + (15'(y) << 5) + 15'(x);

    // NOTE: the array and its read register carry no reset so they map onto block RAM;
    // rd_data is only ever seen through the reset-cleared blank gate below.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            fb[wr_addr] <= colour;
        end
        if (pix_en) begin
            rd_data <= fb[addr_q];
        end
    end

`ifdef PIXEL_SCANOUT_FRAME_PULSE_EN
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= pix_en && (h == H_LAST) && (v == V_VIS - 1'b1);
        end
    end
`endif

    assign vga_hs      = hs_q2;
    assign vga_vs      = vs_q2;
    assign vga_blank_n = vis_q2;
    assign vga_r       = vis_q2 & rd_data[2];
    assign vga_g       = vis_q2 & rd_data[1];
    assign vga_b       = vis_q2 & rd_data[0];
    assign vga_pix_en  = pix_en;

endmodule

// File: tb/tb_pixel_scanout.sv
// Directed bench for pixel_scanout: a full-size instance for pixels and horizontal timing,
// plus a short-frame instance so vertical sync and frame wrap fit in a short run.
`timescale 1ns/1ps
module tb_pixel_scanout;

    logic       clock;
    logic       resetn;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;

    logic hs_a, vs_a, bl_a, r_a, g_a, b_a, pe_a;
    logic hs_b, vs_b, bl_b, r_b, g_b, b_b, pe_b;
`ifdef PIXEL_SCANOUT_FRAME_PULSE_EN
    logic fd_a, fd_b;
`endif

    pixel_scanout dut (
        .clock(clock), .resetn(resetn), .x(x), .y(y), .colour(colour), .plot(plot),
        .vga_hs(hs_a), .vga_vs(vs_a), .vga_blank_n(bl_a),
        .vga_r(r_a), .vga_g(g_a), .vga_b(b_a), .vga_pix_en(pe_a)
`ifdef PIXEL_SCANOUT_FRAME_PULSE_EN
        , .frame_done(fd_a)
`endif
    );

    // 8 visible + 2 front + 2 sync + 3 back = 15 lines = 24000 clocks per frame.
    pixel_scanout #(.V_VISIBLE(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)) dut_v (
        .clock(clock), .resetn(resetn), .x(x), .y(y), .colour(colour), .plot(plot),
        .vga_hs(hs_b), .vga_vs(vs_b), .vga_blank_n(bl_b),
        .vga_r(r_b), .vga_g(g_b), .vga_b(b_b), .vga_pix_en(pe_b)
`ifdef PIXEL_SCANOUT_FRAME_PULSE_EN
        , .frame_done(fd_b)
`endif
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
    endtask

    // Clock edges since reset release; pins show tick p after edge 2p+4.
    int edge_cnt;
    always @(posedge clock or negedge resetn) begin
        if (!resetn) edge_cnt <= 0;
        else         edge_cnt <= edge_cnt + 1;
    end

    int hs_fall_q[$], hs_rise_q[$], bl_rise_q[$], bl_fall_q[$];
    int vs_fall_q[$], vs_rise_q[$], fd_q[$];
    logic prev_hs = 1'b1, prev_bl = 1'b0, prev_vs = 1'b1;

    always @(negedge clock) begin
        if (resetn) begin
            if (prev_hs && !hs_a) hs_fall_q.push_back(edge_cnt);
            if (!prev_hs && hs_a) hs_rise_q.push_back(edge_cnt);
            if (!prev_bl && bl_a) bl_rise_q.push_back(edge_cnt);
            if (prev_bl && !bl_a) bl_fall_q.push_back(edge_cnt);
            if (prev_vs && !vs_b) vs_fall_q.push_back(edge_cnt);
            if (!prev_vs && vs_b) vs_rise_q.push_back(edge_cnt);
`ifdef PIXEL_SCANOUT_FRAME_PULSE_EN
            if (fd_b) fd_q.push_back(edge_cnt);
`endif
        end
        prev_hs <= hs_a;
        prev_bl <= bl_a;
        prev_vs <= vs_b;
    end

    function automatic int qat(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic at_edge(input int e);
        while (edge_cnt < e) @(negedge clock);
    endtask

    task automatic plot_px(input int px, input int py, input logic [2:0] c);
        @(negedge clock);
        x      = 8'(px);
        y      = 7'(py);
        colour = c;
        plot   = 1'b1;
        @(negedge clock);
        plot   = 1'b0;
    endtask

    // Checks {blank_n, r, g, b, pix_en} of the full-size instance for raster tick p.
    task automatic px(input string tag, input int p, input logic [3:0] exp_brgb);
        at_edge(2 * p + 4);
        check(tag, {bl_a, r_a, g_a, b_a, pe_a}, {exp_brgb, 1'b0});
    endtask

    task automatic clear_queues();
        hs_fall_q.delete(); hs_rise_q.delete(); bl_rise_q.delete(); bl_fall_q.delete();
        vs_fall_q.delete(); vs_rise_q.delete(); fd_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, at %0t", $time);
        $fatal(1);
    end

    initial begin
        resetn = 1'b0; plot = 1'b0; x = '0; y = '0; colour = '0;
        repeat (5) @(posedge clock);
        @(negedge clock);
        check("reset_outs_a", {hs_a, vs_a, bl_a, r_a, g_a, b_a, pe_a}, 7'b1100000);
        check("reset_outs_b", {hs_b, vs_b, bl_b, r_b, g_b, b_b, pe_b}, 7'b1100000);
        resetn = 1'b1;

        plot_px(0,   0, 3'b101);
        plot_px(1,   0, 3'b110);
        plot_px(159, 0, 3'b011);
        plot_px(0,   1, 3'b000);
        plot_px(95,  1, 3'b001);
        plot_px(158, 2, 3'b111);
        plot_px(159, 2, 3'b010);
        plot_px(159, 3, 3'b100);
        // Out of range: (160,0) would alias (0,1), (255,0) would alias (95,1).
        plot_px(160, 0, 3'b111);
        plot_px(255, 0, 3'b111);
        plot_px(0, 120, 3'b111);
        plot_px(159, 127, 3'b111);

        // Scan is running; reset must force outputs immediately and restart at (0,0).
        @(negedge clock);
        while (!bl_a) @(negedge clock);
        resetn = 1'b0;
        #1;
        check("async_reset_outs", {hs_a, vs_a, bl_a, r_a, g_a, b_a, pe_a}, 7'b1100000);
        repeat (3) @(negedge clock);
        clear_queues();
        resetn = 1'b1;

        at_edge(1);
        check("pix_en_edge1", pe_a, 1'b1);
        at_edge(2);
        check("pix_en_edge2", pe_a, 1'b0);

        px("px_l0_h0",     0,    4'b1_101);
        px("px_l0_h3",     3,    4'b1_101);
        px("px_l0_h4",     4,    4'b1_110);
        px("px_l0_h636",   636,  4'b1_011);
        px("px_l0_h639",   639,  4'b1_011);
        px("px_l0_h640",   640,  4'b0_000);
        px("px_l0_h799",   799,  4'b0_000);
        px("px_l3_h0",     2400, 4'b1_101);
        px("px_l3_h3",     2403, 4'b1_101);
        px("px_l4_h0",     3200, 4'b1_000);
        px("px_l4_h380",   3580, 4'b1_001);
        at_edge(2 * 6400 + 4);
        check("v_b_l8_blank", {bl_b, r_b, g_b, b_b}, 4'b0_000);
        px("px_l8_h632",   7032, 4'b1_111);
        px("px_l8_h636",   7036, 4'b1_010);
        px("px_l8_h639",   7039, 4'b1_010);
        px("px_l11_h639",  9439, 4'b1_010);
        px("px_l12_h636", 10236, 4'b1_100);

        check("hs_first_fall",  qat(hs_fall_q, 0), 1316);
        check("hs_low_clocks",  qat(hs_rise_q, 0) - qat(hs_fall_q, 0), 192);
        check("line_period",    qat(hs_fall_q, 1) - qat(hs_fall_q, 0), 1600);
        check("blank_first_hi", qat(bl_rise_q, 0), 4);
        check("blank_hi_clocks", qat(bl_fall_q, 0) - qat(bl_rise_q, 0), 1280);
        check("vs_first_fall",  qat(vs_fall_q, 0), 16004);
        check("vs_low_clocks",  qat(vs_rise_q, 0) - qat(vs_fall_q, 0), 3200);

        at_edge(2 * 12000 + 4);
        check("v_b_frame2_px0", {bl_b, r_b, g_b, b_b, pe_b}, 5'b1_101_0);

        at_edge(41000);
        check("frame_period",   qat(vs_fall_q, 1) - qat(vs_fall_q, 0), 24000);
`ifdef PIXEL_SCANOUT_FRAME_PULSE_EN
        check("frame_done_cnt", fd_q.size(), 2);
        check("frame_done_at0", qat(fd_q, 0), 12800);
        check("frame_done_at1", qat(fd_q, 1), 36800);
`endif

        // Mid-frame reset: full-size scan at v=25 (visible), short-frame scan in vsync.
        check("pre_rst_blank_a", bl_a, 1'b1);
        check("pre_rst_vs_b",    vs_b, 1'b0);
        resetn = 1'b0;
        #1;
        check("midrst_outs_a", {hs_a, vs_a, bl_a, r_a, g_a, b_a, pe_a}, 7'b1100000);
        check("midrst_vs_b",   vs_b, 1'b1);
        repeat (3) @(negedge clock);
        clear_queues();
        resetn = 1'b1;

        px("post_rst_px0", 0, 4'b1_101);
        px("post_rst_px4", 4, 4'b1_110);
        at_edge(1320);
        check("post_rst_hs_fall", qat(hs_fall_q, 0), 1316);
        check("post_rst_vs_b",    vs_b, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
